dummy_schmittbuf_1: RTL and testbench



---
 rtl/dummy_schmittbuf_1_pkg.sv | 11 +
 rtl/dummy_schmittbuf_1_sync.sv | 21 ++
 rtl/dummy_schmittbuf_1.sv | 60 ++++++
 tb/tb_dummy_schmittbuf_1.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dummy_schmittbuf_1_pkg.sv
// schmitt_pkg: shared defaults and parameter checks for the Schmitt buffer
package schmitt_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int RISE_CYCLES_DEF = 4;
  localparam int FALL_CYCLES_DEF = 4;
  function automatic bit cnt_w_ok(input int cnt_w, input int rise, input int fall);
    int m;
    m = (rise > fall) ? rise : fall;
    return cnt_w >= $clog2(m + 1);
  endfunction
endpackage

// File: rtl/dummy_schmittbuf_1_sync.sv
// schmitt_sync: STAGES-flop input synchroniser, async active-low reset to 0
module schmitt_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  if (STAGES == 1) begin : g_one
    always_ff @(posedge clock or negedge resetn)
      if (!resetn) sync_q <= '0;
      else sync_q <= d_i;
  end else begin : g_many
    always_ff @(posedge clock or negedge resetn)
      if (!resetn) sync_q <= '0;
      else sync_q <= {sync_q[STAGES-2:0], d_i};
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/dummy_schmittbuf_1.sv
// dummy_schmittbuf_1: clocked Schmitt-trigger buffer with hysteresis counter and glitch rejection
import schmitt_pkg::*;
module dummy_schmittbuf_1 #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int RISE_CYCLES = RISE_CYCLES_DEF,
  parameter int FALL_CYCLES = FALL_CYCLES_DEF,
  parameter int CNT_W       = 8
) (
`ifdef USE_POWER_PINS
  inout  wire  VPWR,
  inout  wire  VGND,
  inout  wire  VPB,
  inout  wire  VNB,
`endif
  input  logic clock,
  input  logic resetn,
  input  logic A,
  output logic X
);
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 1..4");
  end
  if (RISE_CYCLES < 1 || FALL_CYCLES < 1) begin : g_bad_th
    $error("RISE_CYCLES and FALL_CYCLES must be at least 1");
  end
  if (!cnt_w_ok(CNT_W, RISE_CYCLES, FALL_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the hysteresis thresholds");
  end
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CYCLES - 1);
  logic             a_s;
  logic             hit;
  logic             x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  schmitt_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .resetn(resetn),
    .d_i   (A),
    .q_o   (a_s)
  );
  // cnt counts consecutive samples disagreeing with x_q; flip on the TH-th one
  always_comb begin
    hit   = (a_s != x_q) && (cnt_q == (x_q ? FALL_LAST : RISE_LAST));
    cnt_d = (a_s == x_q || hit) ? '0 : cnt_q + 1'b1;
    x_d   = hit ? a_s : x_q;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      cnt_q <= '0;
      x_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
    end
`ifdef USE_POWER_PINS
  assign X = (VPWR == 1'b1 && VGND == 1'b0) ? x_q : 1'b0;
`else
  assign X = x_q;
`endif
endmodule

// File: tb/tb_dummy_schmittbuf_1.sv
// tb_dummy_schmittbuf_1: vector table, directed corners and randomized run against a sample-history model
module tb_dummy_schmittbuf_1;
  localparam int S  = 2;
  localparam int TR = 4;
  localparam int TF = 4;
  typedef struct {
    logic a;
    logic x;
  } vec_t;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic a_in = 1'b0;
  logic x_out;
  logic ca = 1'b0;
  logic mid, cx, porb;
  int vecs = 0;
  int miss = 0;
  int hist[$];
  int xm = 0;
  int run = 0;
  always #5 clock = ~clock;
  dummy_schmittbuf_1 dut (.clock(clock), .resetn(resetn), .A(a_in), .X(x_out));
  dummy_schmittbuf_1 u1 (.clock(clock), .resetn(resetn), .A(ca), .X(mid));
  dummy_schmittbuf_1 u2 (.clock(clock), .resetn(resetn), .A(mid), .X(cx));
  assign porb = ~cx;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got %0d want %0d at %0t", n, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    hist.delete();
    xm  = 0;
    run = 0;
  endtask
  // model: the level seen by the filter is A as sampled S edges earlier
  task automatic model_step(input int a);
    int n, seen;
    hist.push_back(a);
    n = hist.size();
    seen = (n - 1 - S >= 0) ? hist[n-1-S] : 0;
    if (seen != xm) begin
      run++;
      if (run == (xm != 0 ? TF : TR)) begin
        xm  = seen;
        run = 0;
      end
    end else run = 0;
    if (hist.size() > S + 1) void'(hist.pop_front());
  endtask
  task automatic tick(input logic a);
    a_in = a;
    @(posedge clock);
    #1;
    model_step(int'(a));
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    a_in = 1'b0;
    ca = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_clear();
    chk("reset_x", x_out, 0);
    chk("reset_cnt", dut.cnt_q, 0);
    resetn = 1'b1;
  endtask
  task automatic run_table(input vec_t tv[$], input string n);
    foreach (tv[i]) begin
      tick(tv[i].a);
      chk(n, x_out, tv[i].x);
    end
  endtask
  initial begin
    vec_t tv[$];
    int mid_edge, edges, len;
    logic a;
    do_reset();
    // rise after 6 edges, 3-cycle low pulse rejected, 4+ low samples fall
    for (int i = 0; i < 5; i++) tv.push_back('{1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b1});
    for (int i = 0; i < 6; i++) tv.push_back('{(i < 3) ? 1'b0 : 1'b1, 1'b1});
    for (int i = 0; i < 5; i++) tv.push_back('{1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b0});
    run_table(tv, "table_basic");
    chk("cnt_after_fall", dut.cnt_q, 0);
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick(1'(i % 2));
      chk("alt_x", x_out, 0);
      chk("alt_cnt_le1", dut.cnt_q <= 1, 1);
    end
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1);
    chk("pre_async_x", x_out, 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_x", x_out, 0);
    model_clear();
    #1;
    resetn = 1'b1;
    tv.delete();
    for (int i = 0; i < 5; i++) tv.push_back('{1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b1});
    run_table(tv, "table_after_async");
    do_reset();
    chk("por_init", porb, 1);
    mid_edge = 0;
    edges = 0;
    ca = 1'b1;
    while (edges < 40 && cx !== 1'b1) begin
      @(posedge clock);
      #1;
      edges++;
      if (mid === 1'b1 && mid_edge == 0) mid_edge = edges;
    end
    chk("chain_mid_edge", mid_edge, 6);
    chk("chain_out_edge", edges, 12);
    chk("chain_porb", porb, 0);
    do_reset();
    a = 1'b0;
    len = 0;
    for (int i = 0; i < 3000; i++) begin
      if (len == 0) begin
        a = ~a;
        len = $urandom_range(1, 7);
      end
      len--;
      tick(a);
      chk("rand_x", x_out, xm);
      chk("rand_cnt", dut.cnt_q, run);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        resetn = 1'b0;
        #1;
        chk("rand_async_x", x_out, 0);
        model_clear();
        resetn = 1'b1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
